// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU command controller: frame tags, error codes
// and the one-hot state encodings of the parser and the byte serializer.
package uart_alu_pkg;

  localparam logic [7:0] TAG_A  = 8'h08;
  localparam logic [7:0] TAG_B  = 8'h10;
  localparam logic [7:0] TAG_OP = 8'h20;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TAG     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_PAY_A  = 6'b000010,
    ST_PAY_B  = 6'b000100,
    ST_PAY_OP = 6'b001000,
    ST_EXEC   = 6'b010000,
    ST_TX     = 6'b100000
  } state_e;

  typedef enum logic [2:0] {
    SER_IDLE = 3'b001,
    SER_SEND = 3'b010,
    SER_WAIT = 3'b100
  } ser_state_e;

endpackage

// File: rtl/uart_byte_serializer.sv
// Sends an NB_DATA-bit word to the UART transmitter one byte at a time, MSB byte
// first, pacing each byte on the transmitter's done strobe.
module uart_byte_serializer
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [NB_DATA-1:0] data,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               done
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int CNT_W    = $clog2(NB_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB_BYTES - 1);

  ser_state_e         state, state_nxt;
  logic [NB_DATA-1:0] sreg;
  logic [CNT_W-1:0]   idx;

  assign tx_start = (state == SER_SEND);
  assign tx_data  = sreg[NB_DATA-1 -: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SER_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      SER_IDLE: if (load) state_nxt = SER_SEND;
      SER_SEND: state_nxt = SER_WAIT;
      SER_WAIT: begin
        if (tx_done) begin
          if (idx == LAST_IDX) begin
            state_nxt = SER_IDLE;
            done      = 1'b1;
          end else begin
            state_nxt = SER_SEND;
          end
        end
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  // The last byte is not shifted out so tx_data stays put until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load && state == SER_IDLE) begin
      sreg <= data;
      idx  <= '0;
    end else if (state == SER_WAIT && tx_done && idx != LAST_IDX) begin
      sreg <= NB_DATA'({sreg, 8'h00});
      idx  <= idx + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_alu_cmd_ctrl.sv
// Command controller between UART RX/TX and the ALU: parses tagged operand/opcode
// frames, fires one ALU evaluation per opcode frame and streams the result back.
module uart_alu_cmd_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid,
  input  logic [NB_DATA-1:0] i_result,
  output logic               o_busy,
  output logic               o_err,
  output logic [1:0]         o_err_code
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int CNT_W    = $clog2(NB_BYTES + 1);
  localparam int TO_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NB_BYTES);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   left;
  logic [TO_W-1:0]    to_cnt;
  logic [NB_DATA-1:0] shadow, shift_val;
  logic               in_payload, last_byte, expired;
  logic               err_set, ser_done;
  logic [1:0]         err_code_nxt;

  assign in_payload = (state == ST_PAY_A) || (state == ST_PAY_B) || (state == ST_PAY_OP);
  assign last_byte  = (left == CNT_ONE);
  assign expired    = (TIMEOUT_CYC > 0) && in_payload && !i_rx_done && (to_cnt == TO_LIMIT);
  assign shift_val  = NB_DATA'({shadow, i_rx});
  assign o_valid    = (state == ST_EXEC);
  assign o_busy     = (state == ST_EXEC) || (state == ST_TX);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    err_set      = 1'b0;
    err_code_nxt = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (i_rx_done) begin
          case (i_rx)
            TAG_A:   state_nxt = ST_PAY_A;
            TAG_B:   state_nxt = ST_PAY_B;
            TAG_OP:  state_nxt = ST_PAY_OP;
            default: begin
              err_set      = 1'b1;
              err_code_nxt = ERR_TAG;
            end
          endcase
        end
      end
      ST_PAY_A, ST_PAY_B, ST_PAY_OP: begin
        if (i_rx_done && last_byte) begin
          state_nxt = (state == ST_PAY_OP) ? ST_EXEC : ST_IDLE;
        end else if (expired) begin
          state_nxt    = ST_IDLE;
          err_set      = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
        end
      end
      ST_EXEC, ST_TX: begin
        if (state == ST_EXEC) state_nxt = ST_TX;
        else if (ser_done)    state_nxt = ST_IDLE;
        // Bytes arriving while busy are dropped; the running sequence is not disturbed.
        if (i_rx_done) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_OVERRUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      left        <= '0;
      to_cnt      <= '0;
      shadow      <= '0;
      o_data_a    <= '0;
      o_data_b    <= '0;
      o_operation <= '0;
      o_err       <= 1'b0;
      o_err_code  <= ERR_NONE;
    end else begin
      o_err <= err_set;
      if (err_set) o_err_code <= err_code_nxt;
      if (state == ST_IDLE && i_rx_done) begin
        left   <= (i_rx == TAG_OP) ? CNT_ONE : CNT_FULL;
        to_cnt <= '0;
      end else if (in_payload) begin
        if (i_rx_done) begin
          shadow <= shift_val;
          left   <= left - CNT_ONE;
          to_cnt <= '0;
          if (last_byte) begin
            if (state == ST_PAY_A)  o_data_a    <= shift_val;
            if (state == ST_PAY_B)  o_data_b    <= shift_val;
            if (state == ST_PAY_OP) o_operation <= i_rx[NB_OP-1:0];
          end
        end else if (TIMEOUT_CYC > 0 && !expired) begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

  // Result is captured at the end of the EXEC cycle, while the ALU sees stable operands.
  uart_byte_serializer #(
    .NB_DATA (NB_DATA)
  ) u_ser (
    .clk      (clk),
    .rst      (i_rst),
    .load     (state == ST_EXEC),
    .data     (i_result),
    .tx_done  (i_tx_done),
    .tx_start (o_tx_start),
    .tx_data  (o_tx_data),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_uart_alu_cmd_ctrl.sv
// Directed bench for uart_alu_cmd_ctrl: an 8-bit and a 16-bit instance, each with a
// short frame timeout, driven from one byte stream steered by sel16.
module tb_uart_alu_cmd_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] rx;
  logic rx_done, tx_done, sel16;
  logic rx_done8, tx_done8, rx_done16, tx_done16;

  logic        tx_start8, valid8, busy8, err8;
  logic [7:0]  tx_data8, a8, b8, result8;
  logic [5:0]  op8;
  logic [1:0]  code8;

  logic        tx_start16, valid16, busy16, err16;
  logic [7:0]  tx_data16;
  logic [15:0] a16, b16, result16;
  logic [5:0]  op16;
  logic [1:0]  code16;

  int n_checks = 0;
  int n_fail   = 0;

  assign rx_done8  = rx_done & ~sel16;
  assign tx_done8  = tx_done & ~sel16;
  assign rx_done16 = rx_done & sel16;
  assign tx_done16 = tx_done & sel16;

  always #5 clk = ~clk;

  uart_alu_cmd_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(20)) u_dut8 (
    .clk(clk), .i_rst(rst), .i_rx(rx), .i_rx_done(rx_done8), .i_tx_done(tx_done8),
    .o_tx_start(tx_start8), .o_tx_data(tx_data8), .o_data_a(a8), .o_data_b(b8),
    .o_operation(op8), .o_valid(valid8), .i_result(result8), .o_busy(busy8),
    .o_err(err8), .o_err_code(code8)
  );

  uart_alu_cmd_ctrl #(.NB_DATA(16), .NB_OP(6), .TIMEOUT_CYC(20)) u_dut16 (
    .clk(clk), .i_rst(rst), .i_rx(rx), .i_rx_done(rx_done16), .i_tx_done(tx_done16),
    .o_tx_start(tx_start16), .o_tx_data(tx_data16), .o_data_a(a16), .o_data_b(b16),
    .o_operation(op16), .o_valid(valid16), .i_result(result16), .o_busy(busy16),
    .o_err(err16), .o_err_code(code16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx      = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  k;
    logic seen;
    rst = 1'b1; rx = '0; rx_done = 1'b0; tx_done = 1'b0; sel16 = 1'b0;
    result8 = '0; result16 = '0;
    repeat (3) step();

    check_eq("rst_a8",      32'(a8), 0);
    check_eq("rst_busy8",   32'(busy8), 0);
    check_eq("rst_txs16",   32'(tx_start16), 0);
    check_eq("rst_code16",  32'(code16), 0);
    rst = 1'b0;
    step();

    // 8-bit: load A, B, then fire opcode 0x20
    result8 = 8'h08;
    send_byte(8'h08); send_byte(8'h05);
    send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h20); send_byte(8'h20);
    check_eq("t1_valid",  32'(valid8), 1);
    check_eq("t1_a",      32'(a8), 'h05);
    check_eq("t1_b",      32'(b8), 'h03);
    check_eq("t1_op",     32'(op8), 'h20);
    check_eq("t1_busy",   32'(busy8), 1);
    step();
    check_eq("t1_valid_off", 32'(valid8), 0);
    check_eq("t1_txs",    32'(tx_start8), 1);
    check_eq("t1_txd",    32'(tx_data8), 'h08);
    step();
    check_eq("t1_txs_off", 32'(tx_start8), 0);
    check_eq("t1_busy_w", 32'(busy8), 1);
    pulse_tx_done();
    check_eq("t1_idle",   32'(busy8), 0);
    check_eq("t1_txd_hold", 32'(tx_data8), 'h08);

    // bad tag
    send_byte(8'h55);
    check_eq("t3_err",    32'(err8), 1);
    check_eq("t3_code",   32'(code8), 1);
    check_eq("t3_a_keep", 32'(a8), 'h05);
    step();
    check_eq("t3_err_pulse", 32'(err8), 0);
    check_eq("t3_code_hold", 32'(code8), 1);
    send_byte(8'h08); send_byte(8'h07);
    check_eq("t3_a_new",  32'(a8), 'h07);
    check_eq("t3_b_keep", 32'(b8), 'h03);

    // frame timeout after 20 idle cycles
    send_byte(8'h08);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 30) begin
      step();
      k++;
      if (err8) seen = 1'b1;
    end
    check_eq("t4_err_seen", 32'(seen), 1);
    check_eq("t4_not_early", 32'(k >= 20), 1);
    check_eq("t4_code",   32'(code8), 2);
    check_eq("t4_a_keep", 32'(a8), 'h07);
    send_byte(8'h08); send_byte(8'h09);
    check_eq("t4_a_next", 32'(a8), 'h09);

    // a byte in the expiry cycle beats the timeout
    send_byte(8'h08);
    repeat (20) step();
    send_byte(8'h0A);
    check_eq("t4b_a",     32'(a8), 'h0A);
    check_eq("t4b_noerr", 32'(err8), 0);
    check_eq("t4b_code",  32'(code8), 2);

    // 16-bit operand and two-byte result
    sel16 = 1'b1;
    result16 = 16'hABCD;
    send_byte(8'h08); send_byte(8'h12); send_byte(8'h34);
    check_eq("t2_a",      32'(a16), 'h1234);
    send_byte(8'h20); send_byte(8'h01);
    check_eq("t2_valid",  32'(valid16), 1);
    check_eq("t2_op",     32'(op16), 'h01);
    step();
    check_eq("t2_txs0",   32'(tx_start16), 1);
    check_eq("t2_txd0",   32'(tx_data16), 'hAB);
    step();
    check_eq("t2_wait0",  32'(tx_start16), 0);
    pulse_tx_done();
    check_eq("t2_txs1",   32'(tx_start16), 1);
    check_eq("t2_txd1",   32'(tx_data16), 'hCD);
    step();
    pulse_tx_done();
    check_eq("t2_idle",   32'(busy16), 0);

    // overrun during TX_WAIT
    send_byte(8'h20); send_byte(8'h02);
    step();
    check_eq("t5_txd0",   32'(tx_data16), 'hAB);
    step();
    send_byte(8'h10);
    check_eq("t5_err",    32'(err16), 1);
    check_eq("t5_code",   32'(code16), 3);
    check_eq("t5_busy",   32'(busy16), 1);
    pulse_tx_done();
    check_eq("t5_txs1",   32'(tx_start16), 1);
    check_eq("t5_txd1",   32'(tx_data16), 'hCD);
    step();
    pulse_tx_done();
    check_eq("t5_idle",   32'(busy16), 0);
    check_eq("t5_b_keep", 32'(b16), 0);
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h01);
    check_eq("t5_a_next", 32'(a16), 'h0001);

    // async reset mid-payload
    send_byte(8'h08); send_byte(8'hAB);
    rst = 1'b1;
    #2;
    check_eq("t6_a_rst",  32'(a16), 0);
    check_eq("t6_code_rst", 32'(code16), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // async reset mid-TX_WAIT
    send_byte(8'h20); send_byte(8'h03);
    step(); step();
    check_eq("t6_busy_pre", 32'(busy16), 1);
    rst = 1'b1;
    #2;
    check_eq("t6_busy_rst", 32'(busy16), 0);
    check_eq("t6_txd_rst",  32'(tx_data16), 0);
    check_eq("t6_op_rst",   32'(op16), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    send_byte(8'h08); send_byte(8'h12); send_byte(8'h34);
    check_eq("t6_a_next", 32'(a16), 'h1234);
    check_eq("t6_noerr",  32'(err16), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
